// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide, start/busy/done handshake and MTHI/MTLO write ports.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t               state_r, state_next_s;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r, acc_next_s, prod_s;
    logic [WIDTH-1:0]     opnd_r, a_orig_r;
    logic                 is_div_r, neg_lo_r, neg_hi_r, b_zero_r;
    logic                 idle_s, accept_s, last_iter_s;
    logic                 is_signed_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_abs_s, b_abs_s;
    logic [WIDTH:0]       addend_s, mul_sum_s, rem_sh_s, diff_s;
    logic [WIDTH-1:0]     res_hi_s, res_lo_s, hi_next_s, lo_next_s;
    logic                 busy_r, done_r, div0_r;
    logic [WIDTH-1:0]     hi_r, lo_r;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        cond_neg = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand decode and accept qualification.
    always_comb begin
        idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
        accept_s    = idle_s && start;
        is_signed_s = ~op[0];
        a_neg_s     = is_signed_s & a[WIDTH-1];
        b_neg_s     = is_signed_s & b[WIDTH-1];
        a_abs_s     = cond_neg(a, a_neg_s);
        b_abs_s     = cond_neg(b, b_neg_s);
        last_iter_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_CALC;
                else          state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (last_iter_s) state_next_s = ST_FIX;
                else             state_next_s = ST_CALC;
            end
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: begin
                if (accept_s) state_next_s = ST_CALC;
                else          state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        if (acc_r[0]) addend_s = {1'b0, opnd_r};
        else          addend_s = {(WIDTH+1){1'b0}};
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
        rem_sh_s  = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s    = rem_sh_s - {1'b0, opnd_r};
        if (is_div_r) begin
            // diff_s[WIDTH] set means the trial subtraction borrowed: restore.
            if (!diff_s[WIDTH]) acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            else                acc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and HI/LO write selection.
    always_comb begin
        if (neg_lo_r) prod_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
        else          prod_s = acc_r;
        if (!is_div_r) begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else if (b_zero_r) begin
            res_hi_s = a_orig_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
            res_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_lo_r);
        end
        hi_next_s = hi_r;
        lo_next_s = lo_r;
        if (state_r == ST_FIX) begin
            hi_next_s = res_hi_s;
            lo_next_s = res_lo_s;
        end else if (idle_s) begin
            if (mthi) hi_next_s = wdata;
            else      hi_next_s = hi_r;
            if (mtlo) lo_next_s = wdata;
            else      lo_next_s = lo_r;
        end else begin
            hi_next_s = hi_r;
            lo_next_s = lo_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            a_orig_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= {{WIDTH{1'b0}}, a_abs_s};
            opnd_r   <= b_abs_s;
            a_orig_r <= a;
            cnt_r    <= {CW{1'b0}};
            is_div_r <= op[1];
            neg_lo_r <= a_neg_s ^ b_neg_s;
            neg_hi_r <= op[1] & a_neg_s;
            b_zero_r <= (b == {WIDTH{1'b0}});
        end else if (state_r == ST_CALC) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Registered status and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            div0_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
            done_r <= (state_next_s == ST_DONE);
            div0_r <= (state_r == ST_FIX) && is_div_r && b_zero_r;
            hi_r   <= hi_next_s;
            lo_r   <= lo_next_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign div0 = div0_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
